// File: rtl/example_lfsr_gen_chk_if.sv
// Bus bundle for the LFSR pattern generator / checker: generator controls, loopback check inputs, status.
// The master side (test harness or controller) drives the controls; the slave side is the generator/checker.
interface example_lfsr_gen_chk_if #(
   parameter int WIDTH = 8
) ();
   logic             enable;
   logic             pause;
   logic             load;
   logic [WIDTH-1:0] ldata;
   logic [WIDTH-1:0] data;
   logic             chk_valid;
   logic [WIDTH-1:0] chk_data;
   logic             clr_err;
   logic             chk_locked;
   logic             chk_err;
   logic [15:0]      err_count;

   modport master (
      output enable, pause, load, ldata, chk_valid, chk_data, clr_err,
      input  data, chk_locked, chk_err, err_count
   );

   modport slave (
      input  enable, pause, load, ldata, chk_valid, chk_data, clr_err,
      output data, chk_locked, chk_err, err_count
   );
endinterface

// File: rtl/example_lfsr_gen_chk.sv
// Galois LFSR pattern generator (STEPS advances per clock) with a self-synchronising read-back checker.
// Define LFSR_CHECKER_EN to build the checker; without it the checker outputs are constant zero.
module example_lfsr_gen_chk #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] POLY     = WIDTH'('h1D),
   parameter logic [WIDTH-1:0] SEED     = WIDTH'(32),
   parameter int               STEPS    = 1,
   parameter int               LOCK_CNT = 4
) (
   input logic                   clk,
   input logic                   reset,
   example_lfsr_gen_chk_if.slave bus
);

   generate
      if (SEED == '0) begin : g_bad_seed
         $error("example_lfsr_gen_chk: SEED must be non-zero");
      end
      if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
         $error("example_lfsr_gen_chk: WIDTH must be 4..64");
      end
      if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
         $error("example_lfsr_gen_chk: STEPS must be 1..WIDTH");
      end
      if (LOCK_CNT < 1 || LOCK_CNT > 255) begin : g_bad_lock
         $error("example_lfsr_gen_chk: LOCK_CNT must be 1..255");
      end
   endgenerate

   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
      return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY : '0);
   endfunction

   // ---------------- generator ----------------
   logic [WIDTH-1:0]            data_reg;
   logic [WIDTH-1:0]            data_next;
   logic [STEPS:0][WIDTH-1:0]   data_chain;

   assign data_chain[0] = data_reg;
   for (genvar gi = 0; gi < STEPS; gi++) begin : g_gen_step
      assign data_chain[gi+1] = lfsr_step(data_chain[gi]);
   end
   assign data_next = data_chain[STEPS];

   // A zero load would freeze the LFSR forever, so it is replaced by SEED.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_reg <= SEED;
      end else if (!bus.enable) begin
         data_reg <= SEED;
      end else if (bus.load) begin
         data_reg <= (bus.ldata == '0) ? SEED : bus.ldata;
      end else if (!bus.pause) begin
         data_reg <= data_next;
      end
   end

   assign bus.data = data_reg;

`ifdef LFSR_CHECKER_EN
   // ---------------- checker ----------------
   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } chk_state_t;

   localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);

   chk_state_t                state_reg;
   logic [WIDTH-1:0]          expected_reg;
   logic [7:0]                cnt_reg;
   logic                      locked_reg;
   logic                      err_reg;
   logic [15:0]               err_count_reg;
   logic [STEPS:0][WIDTH-1:0] exp_chain;
   logic [STEPS:0][WIDTH-1:0] hunt_chain;
   logic                      beat_match;
   logic                      lock_err;

   assign exp_chain[0]  = expected_reg;
   assign hunt_chain[0] = bus.chk_data;
   for (genvar gi = 0; gi < STEPS; gi++) begin : g_chk_step
      assign exp_chain[gi+1]  = lfsr_step(exp_chain[gi]);
      assign hunt_chain[gi+1] = lfsr_step(hunt_chain[gi]);
   end

   assign beat_match = (bus.chk_data == expected_reg);
   assign lock_err   = bus.enable && bus.chk_valid && (state_reg == LOCKED) && !beat_match;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= HUNT;
         expected_reg  <= '0;
         cnt_reg       <= '0;
         locked_reg    <= 1'b0;
         err_reg       <= 1'b0;
         err_count_reg <= '0;
      end else begin
         err_reg <= lock_err;
         // A clear that coincides with an error keeps that error counted.
         if (bus.clr_err) begin
            err_count_reg <= lock_err ? 16'd1 : 16'd0;
         end else if (lock_err && err_count_reg != 16'hFFFF) begin
            err_count_reg <= err_count_reg + 16'd1;
         end

         if (!bus.enable) begin
            state_reg  <= HUNT;
            cnt_reg    <= '0;
            locked_reg <= 1'b0;
         end else if (bus.chk_valid) begin
            case (state_reg)
               HUNT: begin
                  expected_reg <= hunt_chain[STEPS];
                  cnt_reg      <= '0;
                  state_reg    <= VERIFY;
               end
               VERIFY: begin
                  if (beat_match) begin
                     expected_reg <= exp_chain[STEPS];
                     if (cnt_reg == LOCK_LAST) begin
                        state_reg  <= LOCKED;
                        locked_reg <= 1'b1;
                     end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                     end
                  end else begin
                     state_reg <= HUNT;
                  end
               end
               LOCKED: begin
                  expected_reg <= exp_chain[STEPS];
               end
               default: begin
                  state_reg  <= HUNT;
                  locked_reg <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.chk_locked = locked_reg;
   assign bus.chk_err    = err_reg;
   assign bus.err_count  = err_count_reg;
`else
   logic unused_chk_inputs;
   assign unused_chk_inputs = ^{bus.chk_valid, bus.chk_data, bus.clr_err};

   assign bus.chk_locked = 1'b0;
   assign bus.chk_err    = 1'b0;
   assign bus.err_count  = 16'd0;
`endif

endmodule

// File: tb/tb_example_lfsr_gen_chk.sv
// Scoreboarded bench for example_lfsr_gen_chk: STEPS=1 and STEPS=2 instances share one stimulus stream.
// Checker scenarios run when LFSR_CHECKER_EN is defined; otherwise the tied-off outputs are checked.
`timescale 1ns/1ps
module tb_example_lfsr_gen_chk;
   localparam int         W    = 8;
   localparam logic [7:0] SEED = 8'h20;
   localparam logic [7:0] POLY = 8'h1D;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   example_lfsr_gen_chk_if #(.WIDTH(W)) bus ();
   example_lfsr_gen_chk_if #(.WIDTH(W)) bus2 ();

   example_lfsr_gen_chk #(.WIDTH(W), .POLY(POLY), .SEED(SEED), .STEPS(1), .LOCK_CNT(4)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave));
   example_lfsr_gen_chk #(.WIDTH(W), .POLY(POLY), .SEED(SEED), .STEPS(2), .LOCK_CNT(4)) dut2 (
      .clk(clk), .reset(reset), .bus(bus2.slave));

   assign bus2.enable    = bus.enable;
   assign bus2.pause     = bus.pause;
   assign bus2.load      = bus.load;
   assign bus2.ldata     = bus.ldata;
   assign bus2.chk_valid = bus.chk_valid;
   assign bus2.chk_data  = bus.chk_data;
   assign bus2.clr_err   = bus.clr_err;

   int         tests_run    = 0;
   int         tests_failed = 0;
   logic [7:0] q1[$];
   logic [7:0] q2[$];
   logic [7:0] md1, md2;
   logic [7:0] t1 [4];
   logic [7:0] t2 [2];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [7:0] ref_step(input logic [7:0] s);
      return {s[6:0], 1'b0} ^ (s[7] ? POLY : 8'h00);
   endfunction

   function automatic logic [7:0] ref_next(input logic [7:0] s, input logic en, input logic pa,
                                           input logic ld, input logic [7:0] ldv, input int n);
      logic [7:0] r;
      r = s;
      if (!en)     r = SEED;
      else if (ld) r = (ldv == 8'h00) ? SEED : ldv;
      else if (!pa) for (int k = 0; k < n; k++) r = ref_step(r);
      return r;
   endfunction

   // One clock: drive inputs, push predicted data, then pop and compare after the edge.
   task automatic cyc(input logic en, input logic pa, input logic ld, input logic [7:0] ldv,
                      input logic cv, input logic corrupt, input logic clr, input logic quiet);
      logic [7:0] e1, e2;
      bus.enable    = en;
      bus.pause     = pa;
      bus.load      = ld;
      bus.ldata     = ldv;
      bus.chk_valid = cv;
      bus.chk_data  = bus.data ^ {7'b0, corrupt};
      bus.clr_err   = clr;
      md1 = ref_next(md1, en, pa, ld, ldv, 1);
      md2 = ref_next(md2, en, pa, ld, ldv, 2);
      q1.push_back(md1);
      q2.push_back(md2);
      @(posedge clk);
      #1;
      if (q1.size() == 0 || q2.size() == 0) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL sb_empty: got no entry expected one");
      end else begin
         e1 = q1.pop_front();
         e2 = q2.pop_front();
         if (!quiet) begin
            check_val("data_s1", {24'b0, bus.data}, {24'b0, e1});
            check_val("data_s2", {24'b0, bus2.data}, {24'b0, e2});
         end
      end
      $display("[TB] cyc en=%0b pa=%0b ld=%0b cv=%0b bad=%0b clr=%0b -> data=%h data2=%h lock=%0b err=%0b cnt=%0d",
               en, pa, ld, cv, corrupt, clr, bus.data, bus2.data, bus.chk_locked, bus.chk_err, bus.err_count)
         ;
   endtask

   task automatic check_status(input string tag, input logic lk, input logic er, input logic [15:0] cnt);
      check_val({tag, "_locked"}, {31'b0, bus.chk_locked}, {31'b0, lk});
      check_val({tag, "_err"},    {31'b0, bus.chk_err},    {31'b0, er});
      check_val({tag, "_count"},  {16'b0, bus.err_count},  {16'b0, cnt});
   endtask

   initial begin
      #10_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      t1 = '{8'h40, 8'h80, 8'h1D, 8'h3A};
      t2 = '{8'h80, 8'h3A};
      reset         = 1'b1;
      bus.enable    = 1'b0;
      bus.pause     = 1'b0;
      bus.load      = 1'b0;
      bus.ldata     = 8'h00;
      bus.chk_valid = 1'b0;
      bus.chk_data  = 8'h00;
      bus.clr_err   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_data_s1", {24'b0, bus.data},  32'h20);
      check_val("rst_data_s2", {24'b0, bus2.data}, 32'h20);
      check_status("rst", 1'b0, 1'b0, 16'd0);
      reset = 1'b0;
      md1 = SEED;
      md2 = SEED;

      // Free-running sequence for both step counts
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0, 0, 8'h00, 0, 0, 0, 0);
         check_val("seq_s1", {24'b0, bus.data}, {24'b0, t1[i]});
         if (i < 2) check_val("seq_s2", {24'b0, bus2.data}, {24'b0, t2[i]});
      end

      // Load, zero-load, disable
      cyc(1, 0, 1, 8'h1D, 0, 0, 0, 0);
      check_val("load_1d", {24'b0, bus.data}, 32'h1D);
      cyc(1, 0, 0, 8'h00, 0, 0, 0, 0);
      check_val("adv_3a", {24'b0, bus.data}, 32'h3A);
      cyc(1, 0, 1, 8'h00, 0, 0, 0, 0);
      check_val("load_zero", {24'b0, bus.data}, 32'h20);
      cyc(1, 0, 0, 8'h00, 0, 0, 0, 0);
      cyc(1, 0, 0, 8'h00, 0, 0, 0, 0);
      cyc(0, 0, 0, 8'h00, 0, 0, 0, 0);
      check_val("disable", {24'b0, bus.data}, 32'h20);

      // Pause holds; load beats pause
      cyc(1, 0, 0, 8'h00, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 1, 0, 8'h00, 0, 0, 0, 0);
         check_val("pause_hold", {24'b0, bus.data}, 32'h40);
      end
      cyc(1, 1, 1, 8'h55, 0, 0, 0, 0);
      check_val("pause_load", {24'b0, bus.data}, 32'h55);

`ifdef LFSR_CHECKER_EN
      // Acquire lock: one HUNT beat plus four matching VERIFY beats
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0, 0, 8'h00, 1, 0, 0, 0);
         check_val("pre_lock", {31'b0, bus.chk_locked}, 32'd0);
      end
      cyc(1, 0, 0, 8'h00, 1, 0, 0, 0);
      check_status("lock", 1'b1, 1'b0, 16'd0);
      cyc(1, 0, 0, 8'h00, 1, 1, 0, 0);
      check_status("lock_err", 1'b1, 1'b1, 16'd1);
      cyc(1, 0, 0, 8'h00, 1, 0, 0, 0);
      check_status("err_pulse_end", 1'b1, 1'b0, 16'd1);

      // Disable drops lock; a VERIFY mismatch returns to HUNT silently
      cyc(0, 0, 0, 8'h00, 0, 0, 0, 0);
      check_status("disable_unlock", 1'b0, 1'b0, 16'd1);
      cyc(1, 0, 0, 8'h00, 1, 0, 0, 0);
      cyc(1, 0, 0, 8'h00, 1, 0, 0, 0);
      cyc(1, 0, 0, 8'h00, 1, 1, 0, 0);
      check_status("verify_miss", 1'b0, 1'b0, 16'd1);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0, 0, 8'h00, 1, 0, 0, 0);
         check_val("relock_wait", {31'b0, bus.chk_locked}, 32'd0);
      end
      cyc(1, 0, 0, 8'h00, 1, 0, 0, 0);
      check_status("relock", 1'b1, 1'b0, 16'd1);

      // Clear interaction
      cyc(1, 0, 0, 8'h00, 1, 1, 0, 0);
      check_status("second_err", 1'b1, 1'b1, 16'd2);
      cyc(1, 0, 0, 8'h00, 1, 1, 1, 0);
      check_status("clr_with_err", 1'b1, 1'b1, 16'd1);
      cyc(1, 0, 0, 8'h00, 1, 0, 1, 0);
      check_status("clr_alone", 1'b1, 1'b0, 16'd0);

      // Saturation
      for (int i = 0; i < 65540; i++) begin
         bus.enable    = 1'b1;
         bus.pause     = 1'b0;
         bus.load      = 1'b0;
         bus.chk_valid = 1'b1;
         bus.chk_data  = bus.data ^ 8'h01;
         bus.clr_err   = 1'b0;
         md1 = ref_next(md1, 1, 0, 0, 8'h00, 1);
         md2 = ref_next(md2, 1, 0, 0, 8'h00, 2);
         @(posedge clk);
         #1;
      end
      check_val("sat_data", {24'b0, bus.data}, {24'b0, md1});
      check_status("saturate", 1'b1, 1'b1, 16'hFFFF);
`else
      for (int i = 0; i < 8; i++) begin
         cyc(1, 0, 0, 8'h00, 1, (i % 3 == 2) ? 1'b1 : 1'b0, 0, 0);
         check_status("no_checker", 1'b0, 1'b0, 16'd0);
      end
`endif

      // Asynchronous reset mid-run takes effect without a clock edge
      cyc(1, 0, 0, 8'h00, 1, 0, 0, 0);
      #2;
      reset = 1'b1;
      #1;
      check_val("async_rst_s1", {24'b0, bus.data},  32'h20);
      check_val("async_rst_s2", {24'b0, bus2.data}, 32'h20);
      check_status("async_rst", 1'b0, 1'b0, 16'd0);
      @(posedge clk);
      #1;
      check_status("rst_no_pulse", 1'b0, 1'b0, 16'd0);
      reset = 1'b0;
      q1.delete();
      q2.delete();
      md1 = SEED;
      md2 = SEED;
      cyc(1, 0, 0, 8'h00, 0, 0, 0, 0);
      check_val("post_rst", {24'b0, bus.data}, 32'h40);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
